// File: rtl/data_mem_arbiter.sv
// Arbitrates the data memory port between the CPU memory stage and a DMA burst reader.
// Optional stall/word performance counters are enabled with DATA_MEM_ARBITER_PERF_EN.
module data_mem_arbiter #(
    parameter logic [31:0] ADDR_MAX  = 32'h4AFFF,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_stall,
    input  logic             dma_start,
    input  logic [31:0]      dma_base,
    input  logic [LEN_W-1:0] dma_len,
    output logic [31:0]      dma_rdata,
    output logic             dma_rvalid,
    output logic             dma_busy,
    output logic             dma_done,
`ifdef DATA_MEM_ARBITER_PERF_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      dma_words,
`endif
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam int unsigned FAIR_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        DMA_RUN,
        YIELD,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [31:0]        addr, addr_next, addr_inc;
    logic [LEN_W-1:0]   count, count_next;
    logic [FAIR_W-1:0]  fair, fair_next, fair_inc;
    logic               done_next;
    logic               rvalid_next;
    logic               cpu_owns;

    assign cpu_rdata = mem_rdata;
    assign addr_inc  = addr + 32'd4;

    always_comb begin
        state_next  = state;
        addr_next   = addr;
        count_next  = count;
        fair_next   = fair;
        fair_inc    = '0;
        done_next   = 1'b0;
        rvalid_next = 1'b0;
        cpu_owns    = 1'b1;
        cpu_stall   = 1'b0;
        dma_busy    = 1'b0;

        case (state)
            IDLE: begin
                if (dma_start) begin
                    if (dma_len != '0) begin
                        addr_next  = dma_base;
                        count_next = dma_len;
                        fair_next  = '0;
                        state_next = DMA_RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            DMA_RUN: begin
                cpu_owns    = 1'b0;
                dma_busy    = 1'b1;
                cpu_stall   = cpu_req;
                rvalid_next = 1'b1;
                addr_next   = (addr_inc > ADDR_MAX) ? '0 : addr_inc;
                count_next  = count - LEN_W'(1);
                fair_inc    = cpu_req ? fair + FAIR_W'(1) : '0;
                fair_next   = fair_inc;
                // Finishing the burst takes priority over yielding on its last word.
                if (count == LEN_W'(1)) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else if (cpu_req && (fair_inc == FAIR_W'(MAX_BURST))) begin
                    state_next = YIELD;
                end
            end
            YIELD: begin
                dma_busy   = 1'b1;
                fair_next  = '0;
                state_next = DMA_RUN;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (rst) begin
            cpu_stall = 1'b0;
            dma_busy  = 1'b0;
        end
    end

    // Out-of-range addresses are redirected to word 0 and can never write.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!rst) begin
            if (cpu_owns) begin
                mem_addr  = (cpu_addr > ADDR_MAX) ? '0 : cpu_addr;
                mem_we    = cpu_req & cpu_we & (cpu_addr <= ADDR_MAX);
                mem_wdata = cpu_wdata;
            end else begin
                mem_addr  = (addr > ADDR_MAX) ? '0 : addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            count      <= '0;
            fair       <= '0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            state      <= state_next;
            addr       <= addr_next;
            count      <= count_next;
            fair       <= fair_next;
            dma_rvalid <= rvalid_next;
            dma_done   <= done_next;
            if (rvalid_next) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

`ifdef DATA_MEM_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            dma_words    <= '0;
        end else begin
            if (cpu_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (dma_rvalid && (dma_words != '1)) begin
                dma_words <= dma_words + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data memory port between two requesters:
  - the pipelined processor's memory stage (single-word loads/stores);
  - a DMA streaming-read engine that feeds the VGA path.
- Sequences DMA bursts itself: generates word addresses, counts words, signals completion.
- Enforces bounded CPU starvation through a fairness counter.
- Sits between the processor/DMA and the external data memory; the processor pipeline freezes on cpu_stall.

Parameters:
- ADDR_MAX, 32'h4AFFF, highest legal byte address; accesses above it are redirected.
- MAX_BURST, 8, maximum consecutive DMA words while a CPU request waits.
- LEN_W, 16, width of the DMA word-count input.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- cpu_req  input  1  processor memory stage holds a load or store.
- cpu_we  input  1  store enable (valid with cpu_req).
- cpu_addr  input  32  byte address from the processor.
- cpu_wdata  input  32  store data.
- cpu_rdata  output  32  load data, combinational from mem_rdata.
- cpu_stall  output  1  freeze the processor pipeline this cycle.
- dma_start  input  1  one-cycle pulse that starts a burst.
- dma_base  input  32  burst start byte address, sampled on dma_start.
- dma_len  input  LEN_W  burst length in words, sampled on dma_start.
- dma_rdata  output  32  registered read word.
- dma_rvalid  output  1  dma_rdata valid this cycle.
- dma_busy  output  1  burst in progress.
- dma_done  output  1  one-cycle pulse after the last word is delivered.
- mem_addr  output  32  address to data memory.
- mem_we  output  1  write enable to data memory.
- mem_wdata  output  32  write data to data memory.
- mem_rdata  input  32  asynchronous read data from data memory.

Behaviour:
- Memory model: asynchronous read, synchronous write on the rising edge of clk.
- Reset (rst=1 at a rising edge):
  - state=IDLE; word counter, address register and fairness counter cleared.
  - dma_rvalid=0, dma_done=0, dma_busy=0, dma_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - A burst in flight is abandoned: no dma_done, no further rvalid.
- Address redirect: any address > ADDR_MAX drives mem_addr=0 and forces mem_we=0; the CPU read returns mem_rdata at address 0.
- IDLE state:
  - CPU owns the port; cpu_stall=0.
  - mem_addr=cpu_addr, mem_we=cpu_req&cpu_we, mem_wdata=cpu_wdata.
  - dma_start with dma_len!=0 loads addr=dma_base and count=dma_len, then moves to DMA_RUN.
  - dma_start with dma_len=0: dma_done pulses the next cycle, state stays IDLE.
- DMA_RUN state (dma_busy=1):
  - Each cycle the DMA owns the port: mem_addr=addr, mem_we=0.
  - Next cycle: dma_rdata<=mem_rdata, dma_rvalid=1.
  - addr+=4; if the new address > ADDR_MAX it wraps to 0. count-=1.
  - cpu_stall=cpu_req.
  - The fairness counter increments on each DMA word while cpu_req=1 and clears when cpu_req=0.
  - When the counter reaches MAX_BURST and cpu_req=1, go to YIELD.
  - When count reaches 0 after the issuing cycle, go to DONE.
- YIELD state (one cycle):
  - CPU owns the port exactly as in IDLE; cpu_stall=0; fairness counter cleared.
  - Return to DMA_RUN.
- DONE state (one cycle):
  - CPU owns the port; dma_done=1 coincides with the last dma_rvalid.
  - dma_busy=0; next state IDLE.
- Simultaneous events:
  - dma_start while dma_busy=1 is ignored.
  - dma_start and cpu_req in the same IDLE cycle: the CPU access completes that cycle and the burst begins next cycle.
- Ownership: cpu_stall is never asserted in IDLE, YIELD or DONE.
- Fairness bound: worst-case CPU stall is MAX_BURST cycles.

Optional Feature:
- Macro: DATA_MEM_ARBITER_PERF_EN.
- Defined:
  - Adds output stall_cycles [31:0], counting cycles with cpu_stall=1.
  - Adds output dma_words [31:0], counting dma_rvalid pulses.
  - Both cleared by rst and saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- CPU store cpu_addr=0x100, cpu_wdata=0xDEADBEEF, then load 0x100 with no DMA -> mem_we=1 for one cycle; cpu_rdata=0xDEADBEEF; cpu_stall never 1.
- dma_start, base=0x200, len=4, memory preloaded with 1,2,3,4 -> dma_rvalid on 4 consecutive cycles with 1,2,3,4; dma_done with the 4th word; dma_busy high for exactly 4 cycles.
- len=20, cpu_req held high from burst start, MAX_BURST=8 -> cpu_stall for 8 cycles, one YIELD cycle with CPU access, then repeats; all 20 words delivered in order.
- dma_base=0x4AFF8, len=3 -> addresses 0x4AFF8, 0x4AFFC, then 0x0; CPU store to 0x4B000 -> mem_we=0, mem_addr=0.
- rst asserted at the 3rd word of a len=10 burst -> next cycle dma_busy=0, dma_rvalid=0, no dma_done; a new dma_start is accepted afterwards.
- dma_len=0 -> dma_done one cycle later; no memory read issued; dma_rvalid stays 0.
